// File: rtl/stall_pkg.sv
// Shared types and default parameters for the stall issuer block.
package stall_pkg;

  localparam int ACK_WINDOW_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int TAG_W_DEF          = 4;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    ACKWAIT,
    HOLD,
    FINISH
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stall_issuer_if.sv
// Request/ack/completion bundle between a stall requester, the delay counter and the issuer.
interface stall_issuer_if #(
  parameter int TAG_W = stall_pkg::TAG_W_DEF
);

  logic             stallReq;
  logic [TAG_W-1:0] stallTag;
  logic             pcEn;
  logic             delayEn;
  logic             busy;
  logic             doneValid;
  logic [TAG_W-1:0] doneTag;
  logic             timeoutErr;
  logic             ovfErr;

  modport master (
    output stallReq, stallTag, pcEn,
    input  delayEn, busy, doneValid, doneTag, timeoutErr, ovfErr
  );

  modport slave (
    input  stallReq, stallTag, pcEn,
    output delayEn, busy, doneValid, doneTag, timeoutErr, ovfErr
  );

endinterface

// File: rtl/stall_timer.sv
// Saturating cycle counter; o_hit flags that the current enabled cycle is the i_limit-th one.
module stall_timer #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [CW-1:0] i_limit,
  output logic          o_hit
);

  logic [CW-1:0] r_count;
  logic [CW:0]   w_count_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // One bit wider so a saturated count cannot wrap the comparison.
  assign w_count_inc = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};
  assign o_hit       = (w_count_inc >= {1'b0, i_limit});

endmodule

// File: rtl/stall_issuer.sv
// Issues one-cycle stall pulses to the delay counter, tracks its ack/hold phases and
// reports completion, with a single-entry pending slot for requests arriving while busy.
module stall_issuer
  import stall_pkg::*;
#(
  parameter int ACK_WINDOW     = ACK_WINDOW_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TAG_W          = TAG_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  stall_issuer_if.slave bus
);

  localparam int            CW      = $clog2(max2(ACK_WINDOW, TIMEOUT_CYCLES) + 1);
  localparam logic [CW-1:0] ACK_LIM = CW'(ACK_WINDOW);
  localparam logic [CW-1:0] TMO_LIM = CW'(TIMEOUT_CYCLES);

  state_t           r_state, w_state_next;
  logic             r_pend_valid, w_pend_valid_next;
  logic [TAG_W-1:0] r_pend_tag, w_pend_tag_next;
  logic [TAG_W-1:0] r_tag, w_tag_next;
  logic             r_timeout_err, w_timeout_set;
  logic             r_ovf_err, w_ovf_set;
  logic             w_req_taken;
  logic             w_tmr_clear, w_tmr_enable, w_tmr_hit;
  logic [CW-1:0]    w_tmr_limit;

  stall_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clear),
    .i_enable (w_tmr_enable),
    .i_limit  (w_tmr_limit),
    .o_hit    (w_tmr_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_pend_valid  <= 1'b0;
      r_pend_tag    <= '0;
      r_tag         <= '0;
      r_timeout_err <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_pend_valid  <= w_pend_valid_next;
      r_pend_tag    <= w_pend_tag_next;
      r_tag         <= w_tag_next;
      r_timeout_err <= r_timeout_err | w_timeout_set;
      r_ovf_err     <= r_ovf_err | w_ovf_set;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pend_valid_next = r_pend_valid;
    w_pend_tag_next   = r_pend_tag;
    w_tag_next        = r_tag;
    w_timeout_set     = 1'b0;
    w_ovf_set         = 1'b0;
    w_tmr_clear       = 1'b0;
    w_tmr_enable      = 1'b0;
    w_tmr_limit       = ACK_LIM;
    w_req_taken       = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (r_pend_valid) begin
          w_tag_next        = r_pend_tag;
          w_pend_valid_next = 1'b0;
          w_state_next      = PULSE;
        end else if (bus.stallReq) begin
          w_tag_next   = bus.stallTag;
          w_req_taken  = 1'b1;
          w_state_next = PULSE;
        end
      end
      PULSE: begin
        w_tmr_clear  = 1'b1;
        w_state_next = ACKWAIT;
      end
      ACKWAIT: begin
        w_tmr_enable = 1'b1;
        w_tmr_limit  = ACK_LIM;
        if (!bus.pcEn) begin
          w_tmr_clear  = 1'b1;
          w_state_next = HOLD;
        end else if (w_tmr_hit) begin
          w_timeout_set = 1'b1;
          w_state_next  = FINISH;
        end
      end
      HOLD: begin
        w_tmr_enable = 1'b1;
        w_tmr_limit  = TMO_LIM;
        if (bus.pcEn) begin
          w_state_next = FINISH;
        end else if (w_tmr_hit) begin
          w_timeout_set = 1'b1;
          w_state_next  = FINISH;
        end
      end
      FINISH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // In IDLE the slot is being drained this cycle, so it can accept a new request.
    if (bus.stallReq && !w_req_taken) begin
      if (!r_pend_valid || (r_state == IDLE)) begin
        w_pend_valid_next = 1'b1;
        w_pend_tag_next   = bus.stallTag;
      end else begin
        w_ovf_set = 1'b1;
      end
    end
  end

  assign bus.delayEn    = (r_state == PULSE);
  assign bus.doneValid  = (r_state == FINISH);
  assign bus.doneTag    = r_tag;
  assign bus.busy       = (r_state != IDLE) || r_pend_valid;
  assign bus.timeoutErr = r_timeout_err;
  assign bus.ovfErr     = r_ovf_err;

endmodule
